// File: rtl/program_memory_loader.sv
// Program memory with a byte-stream loader.
// In RUN the memory answers single-cycle registered fetches; in LOAD it
// assembles incoming bytes big-endian into words and writes them in order
// from address 0, returning to RUN on Load_End or after the last word.
//
// Parameters:
//   AB        address width
//   DB        word width (multiple of 8, 8..64)
//   DEPTH     number of words (1..2**AB)
//   INIT_FILE power-up image name, consumed by the memory preload flow
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   Addr, Rd_En          fetch address / request
//   Data, Data_Valid     registered fetch result, valid one cycle after request
//   Load_Start, Load_End load start / terminate pulses
//   Byte_In, Byte_Valid  load byte stream
//   Load_Busy            high while loading
//   Load_Done            one-cycle pulse on leaving LOAD
//   Load_Err             last load ended with a partial word
//   Words_Loaded         words written by the current or last load
module program_memory_loader #(
  parameter int unsigned AB        = 11,
  parameter int unsigned DB        = 16,
  parameter int unsigned DEPTH     = 2048,
  parameter              INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AB-1:0] Addr,
  input  logic          Rd_En,
  output logic [DB-1:0] Data,
  output logic          Data_Valid,
  input  logic          Load_Start,
  input  logic [7:0]    Byte_In,
  input  logic          Byte_Valid,
  input  logic          Load_End,
  output logic          Load_Busy,
  output logic          Load_Done,
  output logic          Load_Err,
  output logic [AB:0]   Words_Loaded
);

  localparam int unsigned BPW = DB / 8;
  localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned WLW = AB + 1;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DB-1:0]  mem [DEPTH];

  logic [DB-1:0]  data_q, data_nxt;
  logic           dv_q, dv_nxt;
  logic           busy_q, busy_nxt;
  logic           done_q, done_nxt;
  logic           err_q, err_nxt;
  logic [WLW-1:0] words_q, words_nxt;
  logic [CW-1:0]  cnt_q, cnt_nxt, cnt_upd;
  logic [AB-1:0]  waddr_q, waddr_nxt;
  logic [DB-1:0]  acc_q, acc_nxt;
  logic [DB-1:0]  word_c;
  logic           mem_we;
  logic           last_word;
  logic           in_range;

  // The image name is used only by the preload flow, not by logic.
  logic unused_init;
  assign unused_init = (INIT_FILE != "");

  // Shifting the new byte in at the bottom leaves the first byte at the top.
  assign word_c   = DB'({acc_q, Byte_In});
  assign in_range = ({1'b0, Addr} < WLW'(DEPTH));

  // Next-state and output logic.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    dv_nxt    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = err_q;
    words_nxt = words_q;
    cnt_nxt   = cnt_q;
    cnt_upd   = cnt_q;
    waddr_nxt = waddr_q;
    acc_nxt   = acc_q;
    mem_we    = 1'b0;
    last_word = 1'b0;
    case (state)
      RUN: begin
        // A fetch issued with Load_Start still completes.
        if (Rd_En) begin
          dv_nxt   = 1'b1;
          data_nxt = in_range ? mem[Addr] : '0;
        end
        if (Load_Start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
          waddr_nxt = '0;
          words_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      LOAD: begin
        if (Byte_Valid) begin
          acc_nxt = word_c;
          if (cnt_q == CW'(BPW - 1)) begin
            mem_we    = 1'b1;
            cnt_upd   = '0;
            waddr_nxt = waddr_q + AB'(1);
            words_nxt = words_q + WLW'(1);
            last_word = (waddr_q == AB'(DEPTH - 1));
          end else begin
            cnt_upd = cnt_q + CW'(1);
          end
        end
        cnt_nxt = cnt_upd;
        // Load_End sees the byte count after this cycle's byte.
        if (last_word || Load_End) begin
          state_nxt = RUN;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
          if (cnt_upd != '0) err_nxt = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    busy_nxt = (state_nxt == LOAD);
  end

  // State and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      data_q  <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
      cnt_q   <= '0;
      waddr_q <= '0;
      acc_q   <= '0;
    end else begin
      state   <= state_nxt;
      data_q  <= data_nxt;
      dv_q    <= dv_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      words_q <= words_nxt;
      cnt_q   <= cnt_nxt;
      waddr_q <= waddr_nxt;
      acc_q   <= acc_nxt;
    end
  end

  // Memory array is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr_q] <= word_c;
  end

  assign Data         = data_q;
  assign Data_Valid   = dv_q;
  assign Load_Busy    = busy_q;
  assign Load_Done    = done_q;
  assign Load_Err     = err_q;
  assign Words_Loaded = words_q;

endmodule

// File: tb/tb_program_memory_loader.sv
module tb_program_memory_loader;

  localparam int unsigned AB    = 3;
  localparam int unsigned DB    = 16;
  localparam int unsigned DEPTH = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AB-1:0] addr = '0;
  logic          rd_en = 1'b0;
  logic [DB-1:0] data;
  logic          data_valid;
  logic          load_start = 1'b0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          load_end = 1'b0;
  logic          load_busy;
  logic          load_done;
  logic          load_err;
  logic [AB:0]   words_loaded;

  program_memory_loader #(.AB(AB), .DB(DB), .DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk          (clk),
    .reset        (reset),
    .Addr         (addr),
    .Rd_En        (rd_en),
    .Data         (data),
    .Data_Valid   (data_valid),
    .Load_Start   (load_start),
    .Byte_In      (byte_in),
    .Byte_Valid   (byte_valid),
    .Load_End     (load_end),
    .Load_Busy    (load_busy),
    .Load_Done    (load_done),
    .Load_Err     (load_err),
    .Words_Loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: transaction-level view of the loader.
  bit          m_busy = 0, m_dv = 0, m_done = 0, m_err = 0;
  logic [15:0] m_data = '0;
  bit          m_data_known = 1;
  int          m_words = 0;
  logic [15:0] exp_mem [8];
  bit          known [8];
  logic [7:0]  partial [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(data_valid), 64'(m_dv));
    chk({tag, ".busy"},  64'(load_busy), 64'(m_busy));
    chk({tag, ".done"},  64'(load_done), 64'(m_done));
    chk({tag, ".err"},   64'(load_err), 64'(m_err));
    chk({tag, ".words"}, 64'(words_loaded), 64'(m_words));
    if (m_data_known) chk({tag, ".data"}, 64'(data), 64'(m_data));
  endtask

  task automatic model_reset();
    m_busy = 0; m_dv = 0; m_done = 0; m_err = 0; m_words = 0;
    m_data = '0; m_data_known = 1;
    partial.delete();
  endtask

  // Expected effect of one clock edge given the currently driven inputs.
  task automatic model_step();
    m_done = 0;
    if (!m_busy) begin
      m_dv = rd_en;
      if (rd_en) begin
        if (int'(addr) >= DEPTH) begin
          m_data = '0; m_data_known = 1;
        end else begin
          m_data = exp_mem[addr]; m_data_known = known[addr];
        end
      end
      if (load_start) begin
        m_busy = 1; m_words = 0; m_err = 0; partial.delete();
      end
    end else begin
      m_dv = 0;
      if (byte_valid) begin
        partial.push_back(byte_in);
        if (partial.size() == DB / 8) begin
          exp_mem[m_words] = (16'(partial[0]) << 8) | 16'(partial[1]);
          known[m_words] = 1;
          m_words++;
          partial.delete();
          if (m_words == DEPTH) begin m_busy = 0; m_done = 1; end
        end
      end
      if (m_busy && load_end) begin
        if (partial.size() != 0) m_err = 1;
        partial.delete();
        m_busy = 0; m_done = 1;
      end
    end
  endtask

  task automatic cyc(input bit rd, input int a, input bit ls, input bit bv,
                     input logic [7:0] b, input bit le, input string tag);
    rd_en = rd; addr = AB'(a); load_start = ls; byte_valid = bv; byte_in = b; load_end = le;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(0, 0, 0, 0, 8'h00, 0, tag);
  endtask

  task automatic readback(input int a, input string tag);
    cyc(1, a, 0, 0, 8'h00, 0, tag);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin exp_mem[i] = '0; known[i] = 0; end

    // Power-up reset.
    @(posedge clk); #1;
    model_reset();
    check_all("reset");
    reset = 1'b0;

    // Fetch before any load: valid follows request, data unknown.
    readback(0, "fetch0");
    idle("fetch_off");

    // Basic load of two words; a Load_Start inside LOAD is ignored.
    cyc($urandom_range(0, 1) == 1, 2, 1, 0, 8'h00, 0, "ld1_start");
    cyc(0, 0, 0, 1, 8'h03, 0, "ld1_b0");
    cyc(1, 1, 0, 1, 8'h00, 0, "ld1_b1");
    cyc(0, 0, 1, 1, 8'h0B, 0, "ld1_b2");
    cyc(0, 0, 0, 1, 8'h18, 0, "ld1_b3");
    cyc(0, 0, 0, 0, 8'h00, 1, "ld1_end");
    chk("ld1_words_const", 64'(words_loaded), 64'd2);
    chk("ld1_err_const", 64'(load_err), 64'd0);
    idle("ld1_after");
    readback(0, "ld1_rb0");
    chk("ld1_mem0_const", 64'(data), 64'h0300);
    readback(1, "ld1_rb1");
    chk("ld1_mem1_const", 64'(data), 64'h0B18);

    // Partial word: three bytes then Load_End.
    cyc(0, 0, 1, 0, 8'h00, 0, "ld2_start");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'($urandom), 0, "ld2_byte");
    cyc(0, 0, 0, 0, 8'h00, 1, "ld2_end");
    chk("ld2_err_const", 64'(load_err), 64'd1);
    readback(1, "ld2_rb1");
    chk("ld2_mem1_kept", 64'(data), 64'h0B18);
    readback(0, "ld2_rb0");
    // Byte_Valid / Load_End in RUN are ignored.
    cyc(0, 0, 0, 1, 8'hAA, 1, "run_ignore");

    // Full load with gaps: auto exit at DEPTH words, extra byte ignored.
    cyc(0, 0, 1, 0, 8'h00, 0, "ld3_start");
    for (int i = 0; i < 100 && m_busy; i++)
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 7), 0,
          $urandom_range(0, 2) != 0, 8'($urandom), 0, "ld3_byte");
    chk("ld3_words_const", 64'(words_loaded), 64'(DEPTH));
    chk("ld3_done_const", 64'(load_done), 64'd1);
    cyc(0, 0, 0, 1, 8'h55, 0, "ld3_extra");
    for (int a = 0; a < 8; a++) readback(a, "ld3_rb");
    readback(6, "oob6");
    chk("oob6_zero", 64'(data), 64'd0);
    readback(7, "oob7");
    chk("oob7_zero", 64'(data), 64'd0);

    // Load_Start with a fetch; last byte coincident with Load_End.
    cyc(1, 5, 1, 0, 8'h00, 0, "ld4_start_fetch");
    chk("ld4_busy_const", 64'(load_busy), 64'd1);
    cyc(1, 3, 0, 1, 8'($urandom), 0, "ld4_b0");
    cyc(0, 0, 0, 1, 8'($urandom), 1, "ld4_b1_end");
    chk("ld4_err_const", 64'(load_err), 64'd0);
    chk("ld4_words_const", 64'(words_loaded), 64'd1);
    readback(0, "ld4_rb0");

    // Reset during LOAD after three words plus one byte.
    cyc(0, 0, 1, 0, 8'h00, 0, "ld5_start");
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 8'($urandom), 0, "ld5_byte");
    #2;
    reset = 1'b1;
    rd_en = 0; load_start = 0; byte_valid = 0; load_end = 0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk); #1;
    check_all("reset_hold");
    reset = 1'b0;
    for (int a = 0; a < 4; a++) readback(a, "ld5_rb");

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 15) == 0,
          $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 19) == 0, "rand");
    for (int a = 0; a < 8; a++) readback(a, "final_rb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/program_memory_loader.md
PROGRAM_MEMORY_LOADER -- requirements
Module: program_memory_loader

Interface
REQ-001 SHALL have parameter AB, default 11, address width in bits.
REQ-002 SHALL have parameter DB, default 16, word width in bits; legal values are multiples of 8, from 8 to 64.
REQ-003 SHALL have parameter DEPTH, default 2048, number of words; legal range is 1 to 2**AB.
REQ-004 SHALL have parameter INIT_FILE, default "", a binary image loaded at power-up; empty means contents are unspecified.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  reset; asynchronous and active-high.
REQ-007 Addr  input  AB  fetch address.
REQ-008 Rd_En  input  1  fetch request.
REQ-009 Data  output  DB  registered fetch data.
REQ-010 Data_Valid  output  1  Data holds the result of the previous cycle's accepted fetch.
REQ-011 Load_Start  input  1  single-cycle pulse that starts a program load.
REQ-012 Byte_In  input  8  load byte (e.g. from a UART receiver).
REQ-013 Byte_Valid  input  1  Byte_In is valid this cycle.
REQ-014 Load_End  input  1  single-cycle pulse that terminates a load.
REQ-015 Load_Busy  output  1  high while in the LOAD state.
REQ-016 Load_Done  output  1  one-cycle pulse on LOAD exit.
REQ-017 Load_Err  output  1  sticky flag: the last load ended with a partial word.
REQ-018 Words_Loaded  output  AB+1  count of words written by the current or last load.

Function
REQ-019 SHALL implement a two-state FSM: RUN (fetch enabled) and LOAD (write enabled).
REQ-020 In RUN with Rd_En=1, SHALL register Data=Mem[Addr] and set Data_Valid=1 on the next edge; read latency is exactly 1 cycle.
REQ-021 In RUN with Rd_En=0, SHALL set Data_Valid=0 next cycle; Data holds its last value.
REQ-022 For Addr>=DEPTH, a fetch SHALL return Data=0 with Data_Valid=1.
REQ-023 RUN->LOAD on Load_Start=1; entry clears the byte counter, the write address, Words_Loaded and Load_Err.
REQ-024 A Load_Start coinciding with Rd_En in RUN SHALL complete the fetch (Data_Valid=1 next cycle), then enter LOAD.
REQ-025 In LOAD, Rd_En SHALL be ignored, Data_Valid SHALL be 0 and Data SHALL hold its value.
REQ-026 In LOAD, Load_Start SHALL be ignored.
REQ-027 In LOAD, each Byte_Valid=1 SHALL accept Byte_In big-endian: the first byte of a word goes to bits DB-1:DB-8.
REQ-028 On the DB/8-th byte, the word SHALL be written to Mem[write address] at that edge; the write address and Words_Loaded increment and the byte counter returns to 0.
REQ-029 On the edge that writes word DEPTH-1, the block SHALL go LOAD->RUN with Load_Done=1 for one cycle; Words_Loaded=DEPTH.
REQ-030 Load_End in LOAD SHALL cause LOAD->RUN with Load_Done=1 on the next cycle.
REQ-031 If the byte counter is non-zero when Load_End is processed, the partial word SHALL be discarded and Load_Err set to 1.
REQ-032 Byte_Valid and Load_End in the same cycle: the byte SHALL be accepted first, then the end evaluated using the updated byte count.
REQ-033 Byte_Valid and Load_End in RUN SHALL be ignored.
REQ-034 Words_Loaded and Load_Err SHALL hold their values in RUN until the next Load_Start.
REQ-035 Memory contents SHALL persist across RUN/LOAD transitions and are never cleared by logic.

Reset
REQ-036 On reset=1, asynchronously: state=RUN, Data=0, Data_Valid=0, Load_Busy=0, Load_Done=0, Load_Err=0, Words_Loaded=0, byte counter=0, write address=0.
REQ-037 Reset during LOAD SHALL discard the partial word; words already written SHALL be retained in memory.
REQ-038 Memory array contents SHALL be unaffected by reset.

Verification
REQ-039 Reset, then Rd_En=1 with Addr=0 -> one cycle later Data=Mem[0] from INIT_FILE and Data_Valid=1; Rd_En=0 -> Data_Valid=0 next cycle.
REQ-040 Load_Start, then bytes 03,00,0B,18, then Load_End -> Words_Loaded=2, Mem[0]=0x0300, Mem[1]=0x0B18, Load_Done pulses once, Load_Err=0; readback of Addr 0 and 1 matches.
REQ-041 Load of 3 bytes, then Load_End -> Words_Loaded=1, Load_Err=1, Mem[1] unchanged from its prior value.
REQ-042 DEPTH=4: load 8 bytes without Load_End -> auto-exit on the 8th byte, Words_Loaded=4, Load_Done=1; a 9th byte is ignored.
REQ-043 Reset asserted after 3 loaded words plus 1 byte -> state RUN, Words_Loaded=0, Mem[0..2] retained, Mem[3] unchanged.
REQ-044 Same cycle Load_Start + Rd_En(Addr=5) -> Data=Mem[5] with Data_Valid=1 next cycle and Load_Busy=1; Byte_Valid with Load_End in the same cycle completing a word -> word written, Load_Err=0.
